// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared definitions for the 802.11a Viterbi add-compare-select array:
//   default code parameters, the default state count and initial metric,
//   and the arithmetic helpers used by every ACS lane.
//   Functions are written on 32-bit containers with an explicit width
//   argument, so parametrised callers can narrow the result with a cast.
package viterbi_pkg;

  localparam int K_DEF  = 7;
  localparam int SW_DEF = 3;
  localparam int MW_DEF = 8;

  localparam logic [6:0] G0_DEF = 7'o133;
  localparam logic [6:0] G1_DEF = 7'o171;

  localparam int S    = 1 << (K_DEF - 1);
  localparam int INIT = 1 << (MW_DEF - 2);

  // Addition clamped at 2^mw-1 so path metrics never wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          mw);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << mw) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

  // Distance of a soft symbol from the expected code bit; an erased
  // (depunctured) symbol carries no information and so costs nothing.
  function automatic logic [31:0] branch_metric(input logic [31:0] sym,
                                                input logic        code,
                                                input logic        erased,
                                                input int          sw);
    logic [31:0] strong_one;
    strong_one = (32'd1 << sw) - 32'd1;
    if (erased) begin
      return 32'd0;
    end
    return code ? (strong_one - sym) : sym;
  endfunction

  // Encoder output bit for the register contents {u, state}.
  function automatic logic code_bit(input logic [31:0] enc,
                                    input logic [31:0] gen);
    return ^(enc & gen);
  endfunction

endpackage

// File: rtl/viterbi_acs_array_acs_unit.sv
// acs_unit
//   Add-compare-select for a single next-state.
//   Ports:
//     pm0, pm1  metrics of predecessor p0 = {ns[K-3:0],0} and p1 = {ns[K-3:0],1}
//     bm0, bm1  branch metrics of the transitions p0->ns and p1->ns
//     norm      subtract 2^(MW-1) from both candidates before the compare
//     pm_new    surviving metric
//     dec       1 when the survivor comes from p1
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int BW = SW_DEF + 1
) (
  input  logic [MW-1:0] pm0,
  input  logic [MW-1:0] pm1,
  input  logic [BW-1:0] bm0,
  input  logic [BW-1:0] bm1,
  input  logic          norm,
  output logic [MW-1:0] pm_new,
  output logic          dec
);

  localparam logic [MW-1:0] HALF = {1'b1, {(MW-1){1'b0}}};

  logic [MW-1:0] cand0;
  logic [MW-1:0] cand1;

  // Normalisation is only requested when every metric has its MSB set, so
  // each candidate is at least HALF and the subtraction cannot underflow.
  // Ties keep p0, hence the strict compare.
  always_comb begin
    cand0 = MW'(sat_add(32'(pm0), 32'(bm0), MW));
    cand1 = MW'(sat_add(32'(pm1), 32'(bm1), MW));
    if (norm) begin
      cand0 = cand0 - HALF;
      cand1 = cand1 - HALF;
    end
    dec    = (cand1 < cand0);
    pm_new = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_acs_array.sv
// viterbi_acs_array
//   Full-trellis add-compare-select array with soft-decision, erasure-aware
//   branch metrics, registered saturating path metrics and automatic
//   normalisation. One decision vector per accepted symbol pair.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid, in_sof    symbol pair present / first pair of a frame
//     in_sym0, in_sym1    soft symbols (0 = strong '0', 2^SW-1 = strong '1')
//     in_era0, in_era1    erasure flags
//     out_valid           decisions valid (one cycle after in_valid)
//     out_dec             survivor bit per next-state
//     out_best            index of the smallest registered path metric
//     out_norm            normalisation applied on this update
module viterbi_acs_array
  import viterbi_pkg::*;
#(
  parameter int          K  = K_DEF,
  parameter int          SW = SW_DEF,
  parameter int          MW = MW_DEF,
  parameter logic [K-1:0] G0 = K'(G0_DEF),
  parameter logic [K-1:0] G1 = K'(G1_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [SW-1:0]           in_sym0,
  input  logic [SW-1:0]           in_sym1,
  input  logic                    in_era0,
  input  logic                    in_era1,
  output logic                    out_valid,
  output logic [(1<<(K-1))-1:0]   out_dec,
  output logic [K-2:0]            out_best,
  output logic                    out_norm
);

  localparam int            NS      = 1 << (K - 1);
  localparam int            BW      = SW + 1;
  localparam int            BI      = K - 1;
  localparam logic [MW-1:0] INIT_PM = MW'(1) << (MW - 2);

  logic [MW-1:0] pm      [NS];
  logic [MW-1:0] pm_src  [NS];
  logic [MW-1:0] pm_next [NS];
  logic [NS-1:0] dec_next;
  logic          frame_start;
  logic          all_msb;
  logic          norm;
  logic [BI-1:0] best_idx;
  logic [MW-1:0] best_val;

  assign frame_start = in_valid & in_sof;

  // A frame start restarts from the initial metrics and must not inherit a
  // normalisation decision taken from the discarded register contents.
  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NS; i++) begin
      all_msb = all_msb & pm[i][MW-1];
    end
    norm = in_valid & ~in_sof & all_msb;
    for (int i = 0; i < NS; i++) begin
      if (frame_start) begin
        pm_src[i] = (i == 0) ? '0 : INIT_PM;
      end else begin
        pm_src[i] = pm[i];
      end
    end
  end

  // Predecessor wiring and expected code bits are fixed per lane, so they
  // are resolved at elaboration; only the symbol-dependent sums are logic.
  for (genvar ns = 0; ns < NS; ns++) begin : g_acs
    localparam int            P0   = (ns << 1) & (NS - 1);
    localparam int            P1   = P0 | 1;
    localparam int            U    = ns >> (K - 2);
    localparam logic [K-1:0]  ENC0 = K'((U << (K - 1)) | P0);
    localparam logic [K-1:0]  ENC1 = K'((U << (K - 1)) | P1);
    localparam logic          C00  = code_bit(32'(ENC0), 32'(G0));
    localparam logic          C01  = code_bit(32'(ENC0), 32'(G1));
    localparam logic          C10  = code_bit(32'(ENC1), 32'(G0));
    localparam logic          C11  = code_bit(32'(ENC1), 32'(G1));

    logic [BW-1:0] bm0;
    logic [BW-1:0] bm1;

    always_comb begin
      bm0 = BW'(branch_metric(32'(in_sym0), C00, in_era0, SW))
          + BW'(branch_metric(32'(in_sym1), C01, in_era1, SW));
      bm1 = BW'(branch_metric(32'(in_sym0), C10, in_era0, SW))
          + BW'(branch_metric(32'(in_sym1), C11, in_era1, SW));
    end

    acs_unit #(
      .MW (MW),
      .BW (BW)
    ) u_acs (
      .pm0    (pm_src[P0]),
      .pm1    (pm_src[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .norm   (norm),
      .pm_new (pm_next[ns]),
      .dec    (dec_next[ns])
    );
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = pm[0];
    for (int i = 1; i < NS; i++) begin
      if (pm[i] < best_val) begin
        best_val = pm[i];
        best_idx = BI'(i);
      end
    end
  end

  assign out_best = best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        pm[i] <= (i == 0) ? '0 : INIT_PM;
      end
      out_valid <= 1'b0;
      out_dec   <= '0;
      out_norm  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < NS; i++) begin
          pm[i] <= pm_next[i];
        end
        out_dec  <= dec_next;
        out_norm <= norm;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_acs_array.sv
// tb_viterbi_acs_array
//   Scoreboard bench for viterbi_acs_array (K=7, SW=3, MW=8).
//   Stimulus pushes the predicted response of a forward-trellis model (plus
//   hand-derived constants where known); a negedge monitor pops and compares
//   whenever out_valid is high.
module tb_viterbi_acs_array;

  localparam int K  = 7;
  localparam int SW = 3;
  localparam int MW = 8;
  localparam int NS = 64;
  localparam int INIT_PM = 64;
  localparam logic [6:0] GEN0 = 7'o133;
  localparam logic [6:0] GEN1 = 7'o171;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [SW-1:0] in_sym0 = '0;
  logic [SW-1:0] in_sym1 = '0;
  logic          in_era0 = 1'b0;
  logic          in_era1 = 1'b0;
  logic          out_valid;
  logic [NS-1:0] out_dec;
  logic [K-2:0]  out_best;
  logic          out_norm;

  typedef struct packed {
    logic [NS-1:0]    dec;
    logic [K-2:0]     best;
    logic             norm;
    logic [NS*MW-1:0] pm;
    logic             hand_en;
    logic [K-2:0]     hand_best;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_item;
  logic [NS-1:0]    dec_log[$];
  logic [NS-1:0]    log_a[$];
  int               model_pm[NS];
  int               checks = 0;
  int               errors = 0;
  int               norm_count = 0;
  logic             valid_q = 1'b0;
  logic             mon_en = 1'b0;
  logic [NS*MW-1:0] dut_pm_flat;

  viterbi_acs_array dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_sym0   (in_sym0),
    .in_sym1   (in_sym1),
    .in_era0   (in_era0),
    .in_era1   (in_era1),
    .out_valid (out_valid),
    .out_dec   (out_dec),
    .out_best  (out_best),
    .out_norm  (out_norm)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      dut_pm_flat[i*MW +: MW] = dut.pm[i];
    end
  end

  // Expected out_valid: in_valid delayed by exactly one cycle.
  always @(posedge clk) valid_q <= rst ? 1'b0 : in_valid;

  function automatic int parity7(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) r = r ^ ((v >> i) & 1);
    return r;
  endfunction

  function automatic logic [NS*MW-1:0] flatModel();
    logic [NS*MW-1:0] f;
    for (int i = 0; i < NS; i++) f[i*MW +: MW] = MW'(model_pm[i]);
    return f;
  endfunction

  function automatic logic [NS*MW-1:0] flatInit();
    logic [NS*MW-1:0] f;
    for (int i = 0; i < NS; i++) f[i*MW +: MW] = (i == 0) ? 8'd0 : 8'(INIT_PM);
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [NS*MW-1:0] actual,
                             input logic [NS*MW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NS; i++) model_pm[i] = (i == 0) ? 0 : INIT_PM;
  endtask

  // Forward trellis: every (state, input) edge offers a candidate to its
  // successor; scanning predecessors in ascending order with a strict
  // compare gives ties to the even predecessor.
  task automatic modelStep(input logic sof, input int s0, input int s1,
                           input logic e0, input logic e1, output exp_t item);
    int src[NS];
    int nxt[NS];
    logic [NS-1:0] dec;
    logic norm;
    int best;
    norm = !sof;
    for (int i = 0; i < NS; i++) if (model_pm[i] < 128) norm = 1'b0;
    for (int i = 0; i < NS; i++) begin
      src[i] = sof ? ((i == 0) ? 0 : INIT_PM) : model_pm[i];
      nxt[i] = -1;
    end
    dec = '0;
    for (int p = 0; p < NS; p++) begin
      for (int u = 0; u < 2; u++) begin
        int enc, ns, c0, c1, b, cand;
        enc  = (u << 6) | p;
        ns   = enc >> 1;
        c0   = parity7(enc & int'(GEN0));
        c1   = parity7(enc & int'(GEN1));
        b    = (e0 ? 0 : (c0 != 0 ? 7 - s0 : s0)) + (e1 ? 0 : (c1 != 0 ? 7 - s1 : s1));
        cand = src[p] + b;
        if (cand > 255) cand = 255;
        if (norm) cand = cand - 128;
        if (nxt[ns] < 0 || cand < nxt[ns]) begin
          nxt[ns] = cand;
          dec[ns] = ((p & 1) != 0);
        end
      end
    end
    best = 0;
    for (int i = 0; i < NS; i++) begin
      model_pm[i] = nxt[i];
      if (nxt[i] < nxt[best]) best = i;
    end
    item.dec       = dec;
    item.best      = 6'(best);
    item.norm      = norm;
    item.pm        = flatModel();
    item.hand_en   = 1'b0;
    item.hand_best = '0;
  endtask

  task automatic applyStimulus(input logic valid, input logic sof, input int s0, input int s1,
                               input logic e0, input logic e1,
                               input logic hand_en, input int hand_best);
    exp_t item;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = valid;
    in_sof   = sof;
    in_sym0  = 3'(s0);
    in_sym1  = 3'(s1);
    in_era0  = e0;
    in_era1  = e1;
    if (valid) begin
      modelStep(sof, s0, s1, e0, e1, item);
      item.hand_en   = hand_en;
      item.hand_best = 6'(hand_best);
      sb_q.push_back(item);
    end
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    modelReset();
  endtask

  task automatic flush();
    applyIdle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: latency check every cycle, scoreboard pop on every output.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("out_valid_latency", {511'd0, out_valid}, {511'd0, valid_q});
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 512'd1, 512'd0);
        end else begin
          mon_item = sb_q.pop_front();
          checkOutput("out_dec", 512'(out_dec), 512'(mon_item.dec));
          checkOutput("out_best", 512'(out_best), 512'(mon_item.best));
          checkOutput("out_norm", 512'(out_norm), 512'(mon_item.norm));
          checkOutput("pm", dut_pm_flat, mon_item.pm);
          if (mon_item.hand_en) checkOutput("hand_best", 512'(out_best), 512'(mon_item.hand_best));
          dec_log.push_back(out_dec);
          if (out_norm === 1'b1) norm_count++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int bits[7]    = '{1, 0, 1, 1, 0, 0, 1};
  int states[7]  = '{32, 16, 40, 52, 26, 13, 38};
  int seq0[8]    = '{1, 6, 3, 7, 0, 5, 2, 4};
  int seq1[8]    = '{6, 2, 7, 0, 3, 3, 5, 1};
  logic seqe[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int st, c0, c1, enc, d, recovered;
    modelReset();
    doReset();
    mon_en = 1'b1;
    applyIdle();
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 512'(out_valid), 512'd0);
    checkOutput("reset_out_best", 512'(out_best), 512'd0);
    checkOutput("reset_out_dec", 512'(out_dec), 512'd0);
    checkOutput("reset_out_norm", 512'(out_norm), 512'd0);
    checkOutput("reset_pm", dut_pm_flat, flatInit());

    // All-zero symbols: state 0 keeps metric 0 and stays best.
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    flush();
    checkOutput("zero_pm0", 512'(dut.pm[0]), 512'd0);

    // Clean encoded stream: best state tracks the encoder, traceback recovers bits.
    dec_log.delete();
    st = 0;
    for (int i = 0; i < 7; i++) begin
      enc = (bits[i] << 6) | st;
      c0  = parity7(enc & int'(GEN0));
      c1  = parity7(enc & int'(GEN1));
      applyStimulus(1'b1, (i == 0), c0 * 7, c1 * 7, 1'b0, 1'b0, 1'b1, states[i]);
      st = enc >> 1;
    end
    flush();
    checkOutput("encode_log_len", 512'(dec_log.size()), 512'd7);
    st = 38;
    recovered = 0;
    for (int i = 6; i >= 0; i--) begin
      recovered = recovered | (((st >> 5) & 1) << (6 - i));
      d  = (dec_log.size() > i) ? int'(dec_log[i][st]) : 0;
      st = ((st << 1) & 63) | d;
    end
    checkOutput("traceback_bits", 512'(recovered), 512'(7'b1011001));

    // Constant mid-scale symbols: metrics climb ~6..8 per step, so exactly one
    // normalisation falls inside 30 updates.
    norm_count = 0;
    applyStimulus(1'b1, 1'b1, 4, 4, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 29; i++) applyStimulus(1'b1, 1'b0, 4, 4, 1'b0, 1'b0, 1'b0, 0);
    flush();
    checkOutput("norm_pulse_count", 512'(norm_count), 512'd1);

    // Fully erased pairs: no branch cost, first update all ties go to p0.
    dec_log.delete();
    applyStimulus(1'b1, 1'b1, 5, 2, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 6, 1, 1'b1, 1'b1, 1'b1, 0);
    flush();
    checkOutput("erased_first_dec", (dec_log.size() > 0) ? 512'(dec_log[0]) : 512'hdead, 512'd0);
    checkOutput("erased_pm0", 512'(dut.pm[0]), 512'd0);

    // Reset mid-frame, continue without sof, then sof mid-stream.
    applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 7, 1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 2, 6, 1'b0, 1'b0, 1'b0, 0);
    doReset();
    applyIdle();
    @(negedge clk);
    #1;
    checkOutput("midreset_out_valid", 512'(out_valid), 512'd0);
    checkOutput("midreset_pm", dut_pm_flat, flatInit());
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, seq0[i], seq1[i], 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 7, 7, 1'b0, 1'b0, 1'b0, 0);
    flush();

    // Gap-free run, then the same run with a 5-cycle bubble.
    dec_log.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i == 0), seq0[i], seq1[i], seqe[i], 1'b0, 1'b0, 0);
    flush();
    log_a = dec_log;
    dec_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), seq0[i], seq1[i], seqe[i], 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyIdle();
    checkOutput("gap_pm_frozen", dut_pm_flat, flatModel());
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b0, seq0[i], seq1[i], seqe[i], 1'b0, 1'b0, 0);
    flush();
    checkOutput("gap_log_len", 512'(dec_log.size()), 512'(log_a.size()));
    for (int i = 0; i < 8; i++) begin
      if (i < dec_log.size() && i < log_a.size()) checkOutput("gap_dec_match", 512'(dec_log[i]), 512'(log_a[i]));
    end

    flush();
    checkOutput("scoreboard_empty", 512'(sb_q.size()), 512'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
